// File: rtl/memory_responder.sv
// Word-addressed memory model: edge-qualified Read/Write starts, WAIT_STATES+1 cycles to a one-cycle Done pulse.
// Starts are ignored while a transaction is in flight; simultaneous Read/Write starts give an Err pulse.
module memory_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] MAR_addr,
    input  logic [DATA_WIDTH-1:0] MDR_data,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  Done,
    output logic                  Busy,
    output logic                  Err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic                    read_q, write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    op_wr_q;
    logic                    start_rd, start_wr;
    logic                    latch, complete, err_nxt;

    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    assign start_rd = Read  & ~read_q;
    assign start_wr = Write & ~write_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        complete  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                err_nxt = start_rd & start_wr;
                if (start_rd ^ start_wr) begin
                    state_nxt = S_BUSY;
                    cnt_nxt   = 4'(WAIT_STATES);
                    latch     = 1'b1;
                end
            end
            S_BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = S_DONE;
                    complete  = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            op_wr_q <= 1'b0;
            Mdatain <= '0;
            Done    <= 1'b0;
            Err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            read_q  <= Read;
            write_q <= Write;
            Done    <= complete;
            Err     <= err_nxt;
            if (latch) begin
                addr_q  <= MAR_addr;
                data_q  <= MDR_data;
                op_wr_q <= start_wr;
            end
            if (complete && !op_wr_q) begin
                Mdatain <= mem[addr_q];
            end
        end
    end

    // The array has no reset; complete is low while clr is asserted, so an abandoned write never lands.
    always_ff @(posedge clk) begin
        if (complete && op_wr_q) begin
            mem[addr_q] <= data_q;
        end
    end

    assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Randomized bench for memory_responder against an array-based memory/latency model (WAIT_STATES=2 and 0).
module tb_memory_responder;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int WS [2] = '{2, 0};

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          rd_s   [2];
    logic          wr_s   [2];
    logic [AW-1:0] addr_s [2];
    logic [DW-1:0] data_s [2];
    logic [DW-1:0] mdin_s [2];
    logic          done_s [2];
    logic          busy_s [2];
    logic          err_s  [2];

    logic [DW-1:0] ref_mem [2][512];
    bit            known   [2][512];
    logic [DW-1:0] last_rd [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(2)) u_dut (
        .clk(clk), .clr(clr), .Read(rd_s[0]), .Write(wr_s[0]),
        .MAR_addr(addr_s[0]), .MDR_data(data_s[0]), .Mdatain(mdin_s[0]),
        .Done(done_s[0]), .Busy(busy_s[0]), .Err(err_s[0])
    );

    memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .clr(clr), .Read(rd_s[1]), .Write(wr_s[1]),
        .MAR_addr(addr_s[1]), .MDR_data(data_s[1]), .Mdatain(mdin_s[1]),
        .Done(done_s[1]), .Busy(busy_s[1]), .Err(err_s[1])
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction on DUT sel; strobes are low on entry and on exit.
    task automatic do_op(input int sel, input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        addr_s[sel] = a;
        data_s[sel] = d;
        if (is_wr) wr_s[sel] = 1'b1; else rd_s[sel] = 1'b1;
        tick();
        chk("start_busy", 32'(busy_s[sel]), 32'd1);
        rd_s[sel] = 1'b0;
        wr_s[sel] = 1'b0;
        n = 0;
        while (!done_s[sel] && n < 40) begin
            tick();
            n++;
        end
        chk(is_wr ? "wr_latency" : "rd_latency", 32'(n), 32'(WS[sel] + 1));
        if (is_wr) begin
            ref_mem[sel][a] = d;
            known[sel][a]   = 1'b1;
        end else begin
            last_rd[sel] = ref_mem[sel][a];
        end
        chk(is_wr ? "wr_mdatain_held" : "rd_data", mdin_s[sel], last_rd[sel]);
        tick();
        chk("done_one_cycle", 32'({done_s[sel], busy_s[sel]}), 32'd0);
    endtask

    initial begin
        int dcnt, bcnt;
        logic [AW-1:0] a;
        for (int s = 0; s < 2; s++) begin
            rd_s[s] = 1'b0; wr_s[s] = 1'b0; addr_s[s] = '0; data_s[s] = '0; last_rd[s] = '0;
            for (int i = 0; i < 512; i++) known[s][i] = 1'b0;
        end
        repeat (2) tick();
        chk("rst_mdatain", mdin_s[0], 32'd0);
        chk("rst_flags", 32'({done_s[0], busy_s[0], err_s[0]}), 32'd0);
        clr = 1'b1;
        tick();

        do_op(0, 1'b1, 9'h005, 32'h28918000);
        do_op(0, 1'b0, 9'h005, 32'h0);

        do_op(0, 1'b1, 9'h000, 32'h15);
        do_op(0, 1'b1, 9'h1FF, 32'h18);
        do_op(0, 1'b0, 9'h000, 32'h0);
        do_op(0, 1'b0, 9'h1FF, 32'h0);

        // Held Read: one transaction, three busy-only cycles then one Done cycle.
        addr_s[0] = 9'h005;
        rd_s[0]   = 1'b1;
        dcnt = 0; bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 8) rd_s[0] = 1'b0;
            if (done_s[0]) begin
                dcnt++;
                chk("hold_busy_in_done", 32'(busy_s[0]), 32'd1);
            end
            if (busy_s[0] && !done_s[0]) bcnt++;
        end
        last_rd[0] = ref_mem[0][9'h005];
        chk("hold_done_count", 32'(dcnt), 32'd1);
        chk("hold_busy_cycles", 32'(bcnt), 32'(WS[0] + 1));
        chk("hold_rd_data", mdin_s[0], last_rd[0]);

        // Simultaneous Read/Write starts.
        addr_s[0] = 9'h005;
        data_s[0] = 32'hCAFEF00D;
        rd_s[0] = 1'b1; wr_s[0] = 1'b1;
        tick();
        chk("err_pulse", 32'({err_s[0], busy_s[0]}), 32'h2);
        rd_s[0] = 1'b0; wr_s[0] = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) chk("err_one_cycle", 32'(err_s[0]), 32'd0);
            if (done_s[0] || busy_s[0]) dcnt++;
        end
        chk("err_no_txn", 32'(dcnt), 32'd0);
        chk("err_mdatain", mdin_s[0], last_rd[0]);
        do_op(0, 1'b0, 9'h005, 32'h0);

        // Randomized traffic over the full address range.
        for (int i = 0; i < 40; i++) begin
            a = AW'($urandom_range(0, 511));
            if (known[0][a] && $urandom_range(0, 1) == 1) do_op(0, 1'b0, a, 32'h0);
            else do_op(0, 1'b1, a, $urandom);
        end

        // Reset in the middle of a write.
        do_op(0, 1'b1, 9'h010, 32'h11111111);
        addr_s[0] = 9'h010;
        data_s[0] = 32'hDEADBEEF;
        wr_s[0] = 1'b1;
        tick();
        wr_s[0] = 1'b0;
        tick();
        clr = 1'b0;
        #1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        chk("mid_rst_mdatain", mdin_s[0], 32'd0);
        chk("mid_rst_flags", 32'({done_s[0], busy_s[0], err_s[0]}), 32'd0);
        #2;
        clr = 1'b1;
        repeat (2) tick();
        do_op(0, 1'b0, 9'h010, 32'h0);

        // Zero wait states, with a Write start ignored while busy.
        do_op(1, 1'b1, 9'h005, 32'h000000A5);
        addr_s[1] = 9'h005;
        rd_s[1] = 1'b1;
        tick();
        rd_s[1] = 1'b0;
        data_s[1] = 32'h5A5A5A5A;
        wr_s[1] = 1'b1;
        tick();
        chk("ws0_done_e1", 32'(done_s[1]), 32'd1);
        chk("ws0_rd_data", mdin_s[1], 32'h000000A5);
        last_rd[1] = 32'h000000A5;
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy_s[1]) dcnt++;
        end
        wr_s[1] = 1'b0;
        chk("ws0_ignored_start", 32'(dcnt), 32'd0);
        tick();
        do_op(1, 1'b0, 9'h005, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
